// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding RV64I load/store unit with alignment fault detection.
// Ports: clk/rst (sync, active high); req_* request handshake (valid/ready, we, funct3,
// addr, wdata); resp_* one-cycle completion pulse with extended load data and fault flag;
// mem_* byte-addressed data-memory port (read enable, byte write mask, addresses,
// write data, combinational read data with the addressed byte in bits [7:0]).
module mem_access_unit #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_misalign,
    output logic              mem_rden,
    output logic [7:0]        mem_wren,
    output logic [ADDR_W-1:0] mem_rdaddress,
    output logic [ADDR_W-1:0] mem_wraddress,
    output logic [63:0]       mem_write_data,
    input  logic [63:0]       mem_read_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state_q, state_d;
    logic we_q, we_d;
    logic [2:0] funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic misalign_q, misalign_d;
    logic accept, misaligned, fault;
    logic [63:0] load_ext;
    logic [7:0] size_mask;
    assign accept = req_valid && state_q == IDLE;
    // Address must be a multiple of the 2^funct3[1:0]-byte access size.
    assign misaligned = req_funct3[1:0] == 2'd0 ? 1'b0 :
                        req_funct3[1:0] == 2'd1 ? req_addr[0] :
                        req_funct3[1:0] == 2'd2 ? |req_addr[1:0] : |req_addr[2:0];
    assign fault = misaligned || (req_we && req_funct3[2]) || (!req_we && req_funct3 == 3'b111);
    assign size_mask = funct3_q[1:0] == 2'd0 ? 8'h01 :
                       funct3_q[1:0] == 2'd1 ? 8'h03 :
                       funct3_q[1:0] == 2'd2 ? 8'h0F : 8'hFF;
    always_comb begin
        case (funct3_q)
            3'd0:    load_ext = {{56{mem_read_data[7]}}, mem_read_data[7:0]};
            3'd1:    load_ext = {{48{mem_read_data[15]}}, mem_read_data[15:0]};
            3'd2:    load_ext = {{32{mem_read_data[31]}}, mem_read_data[31:0]};
            3'd4:    load_ext = {56'd0, mem_read_data[7:0]};
            3'd5:    load_ext = {48'd0, mem_read_data[15:0]};
            3'd6:    load_ext = {32'd0, mem_read_data[31:0]};
            default: load_ext = mem_read_data;
        endcase
    end
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    // Faults skip the memory cycle; the response registers update
                    // together with entering RESP so they change only at resp_valid.
                    if (fault) begin
                        state_d    = RESP;
                        rdata_d    = 64'd0;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                state_d    = RESP;
                rdata_d    = we_q ? 64'd0 : load_ext;
                misalign_d = 1'b0;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 64'd0;
            rdata_q    <= 64'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end
    assign req_ready      = state_q == IDLE;
    assign resp_valid     = state_q == RESP;
    assign resp_rdata     = rdata_q;
    assign resp_misalign  = misalign_q;
    assign mem_rden       = state_q == ACCESS && !we_q;
    assign mem_wren       = (state_q == ACCESS && we_q) ? size_mask : 8'h00;
    assign mem_rdaddress  = addr_q;
    assign mem_wraddress  = addr_q;
    assign mem_write_data = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a byte-array reference model for mem_access_unit.
module tb_mem_access_unit;
    logic clk = 1'b0, rst = 1'b1, mem_init = 1'b1;
    logic req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0] req_funct3 = 3'd0;
    logic [15:0] req_addr = 16'd0;
    logic [63:0] req_wdata = 64'd0;
    logic resp_valid, resp_misalign, mem_rden;
    logic [63:0] resp_rdata, mem_write_data, mem_read_data;
    logic [7:0] mem_wren;
    logic [15:0] mem_rdaddress, mem_wraddress;
    logic [7:0] tb_mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    int cyc = 0, n_chk = 0, n_fail = 0;
    typedef struct {
        logic we;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic mis;
        logic [7:0] wren;
        logic rden;
        int lat;
        int acc;
        int t0;
    } exp_t;
    exp_t sb[$];

    mem_access_unit #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_rdaddress(mem_rdaddress),
        .mem_wraddress(mem_wraddress), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        if (i == 32) return 8'h80;
        if (i == 33) return 8'hFF;
        if (i > 33 && i < 40) return 8'h00;
        return 8'((i * 73 + 11) ^ (i >> 8));
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 65536; i++) tb_mem[i] <= init_byte(i);
        end else begin
            for (int i = 0; i < 8; i++)
                if (mem_wren[i]) tb_mem[mem_wraddress + 16'(i)] <= mem_write_data[i*8 +: 8];
        end
    end
    for (genvar g = 0; g < 8; g++) begin : g_rd
        assign mem_read_data[g*8 +: 8] = tb_mem[mem_rdaddress + 16'(g)];
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", n, a, e);
        end
    endtask

    // Reference: size-byte little-endian access on a byte array, arithmetic sign fill.
    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [15:0] a, input logic [63:0] d);
        exp_t e;
        int sz = 1 << f3[1:0];
        logic [63:0] v = 64'd0;
        e.we = we; e.addr = a; e.wdata = d; e.rdata = 64'd0; e.mis = 1'b0;
        e.wren = 8'h00; e.rden = 1'b0; e.lat = 2; e.acc = 1; e.t0 = 0;
        if ((int'(a) % sz) != 0 || (we && f3 >= 3'd4) || (!we && f3 == 3'd7)) begin
            e.mis = 1'b1; e.lat = 1; e.acc = 0;
        end else if (we) begin
            for (int i = 0; i < sz; i++) ref_mem[a + 16'(i)] = d[i*8 +: 8];
            e.wren = 8'((1 << sz) - 1);
        end else begin
            for (int i = 0; i < sz; i++) v = v | (64'(ref_mem[a + 16'(i)]) << (8 * i));
            if (f3 < 3'd4 && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8 * sz));
            e.rdata = v; e.rden = 1'b1;
        end
        return e;
    endfunction

    task automatic drive(input logic we, input logic [2:0] f3, input logic [15:0] a,
                         input logic [63:0] d);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    endtask

    task automatic wait_accept(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk);
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: req_ready never seen within 20 cycles");
            req_valid = 1'b0;
        end
    endtask

    // Called #1 after a posedge; returns #1 after the following posedge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [15:0] a,
                         input logic [63:0] d);
        exp_t e;
        bit got;
        drive(we, f3, a, d);
        wait_accept(got);
        if (!got) return;
        e = model(we, f3, a, d);
        e.t0 = cyc;
        sb.push_back(e);
        #1 drive(1'($urandom), 3'($urandom), 16'($urandom), {$urandom, $urandom});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic check_idle_zero(input string n);
        chk({n, "_ready"}, 64'(req_ready), 64'd1);
        chk({n, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({n, "_rdata"}, resp_rdata, 64'd0);
        chk({n, "_misalign"}, 64'(resp_misalign), 64'd0);
        chk({n, "_rden"}, 64'(mem_rden), 64'd0);
        chk({n, "_wren"}, 64'(mem_wren), 64'd0);
        chk({n, "_rdaddr"}, 64'(mem_rdaddress), 64'd0);
        chk({n, "_wraddr"}, 64'(mem_wraddress), 64'd0);
        chk({n, "_wdata"}, mem_write_data, 64'd0);
    endtask

    task automatic issue_abort(input logic we, input logic [2:0] f3, input logic [15:0] a,
                               input logic [63:0] d);
        exp_t e;
        bit got;
        drive(we, f3, a, d);
        wait_accept(got);
        if (!got) return;
        e = model(we, f3, a, d);
        e.t0 = cyc;
        sb.push_back(e);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        sb.delete();
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_zero("abort");
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor: checks handshake, memory-port activity and responses against the scoreboard.
    logic [63:0] hold_rdata = 64'd0;
    logic hold_mis = 1'b0;
    int acc_seen = 0;
    always @(negedge clk) begin
        if (rst) begin
            hold_rdata = 64'd0; hold_mis = 1'b0; acc_seen = 0;
        end else begin
            chk("ready", 64'(req_ready), 64'(sb.size() == 0));
            if (mem_wren != 8'h00 || mem_rden) begin
                if (sb.size() == 0) begin
                    chk("spurious_access", {55'd0, mem_rden, mem_wren}, 64'd0);
                end else begin
                    chk("wren", 64'(mem_wren), 64'(sb[0].wren));
                    chk("rden", 64'(mem_rden), 64'(sb[0].rden));
                    chk("rdaddr", 64'(mem_rdaddress), 64'(sb[0].addr));
                    chk("wraddr", 64'(mem_wraddress), 64'(sb[0].addr));
                    if (sb[0].we) chk("wdata", mem_write_data, sb[0].wdata);
                    acc_seen++;
                end
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_resp", 64'(resp_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_misalign", 64'(resp_misalign), 64'(e.mis));
                    chk("latency", 64'(cyc - e.t0), 64'(e.lat));
                    chk("access_count", 64'(acc_seen), 64'(e.acc));
                    chk("resp_addr", 64'(mem_rdaddress), 64'(e.addr));
                    hold_rdata = e.rdata; hold_mis = e.mis; acc_seen = 0;
                end
            end else begin
                chk("hold_rdata", resp_rdata, hold_rdata);
                chk("hold_misalign", 64'(resp_misalign), 64'(hold_mis));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; mem_init = 1'b0;
        @(negedge clk);
        check_idle_zero("reset");
        @(posedge clk);
        #1;
        issue(1'b1, 3'd3, 16'h0010, 64'h1122334455667788);
        issue(1'b0, 3'd0, 16'h0020, 64'd0);
        issue(1'b0, 3'd4, 16'h0020, 64'd0);
        issue(1'b0, 3'd1, 16'h0020, 64'd0);
        issue(1'b0, 3'd2, 16'h0022, 64'd0);
        issue(1'b1, 3'd1, 16'h0011, 64'hABCD);
        issue(1'b1, 3'd2, 16'h0004, 64'hDEADBEEF_CAFEF00D);
        issue(1'b0, 3'd3, 16'h0000, 64'd0);
        issue_abort(1'b1, 3'd0, 16'h0030, 64'h5A);
        issue(1'b0, 3'd7, 16'h0020, 64'd0);
        issue(1'b1, 3'd4, 16'h0020, 64'h77);
        issue(1'b1, 3'd3, 16'hFFF8, 64'h8899AABBCCDDEEFF);
        issue(1'b0, 3'd3, 16'hFFF8, 64'd0);
        issue(1'b0, 3'd0, 16'hFFFF, 64'd0);
        issue(1'b0, 3'd6, 16'hFFFC, 64'd0);
        issue(1'b0, 3'd2, 16'hFFFC, 64'd0);
        for (int n = 0; n < 250; n++) begin
            logic [2:0] f3 = 3'($urandom);
            logic [15:0] a = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 9) < 7) a = a & ~16'((1 << f3[1:0]) - 1);
            issue(1'($urandom), f3, a, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
